seq_subtractor: RTL

SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

---
 rtl/seq_subtractor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seq_subtractor.sv
// ----------------------------------------------------------------------------
// seq_subtractor
//
// Digit-serial subtractor. Computes D = a - b (mod 2^WIDTH) as a + ~b + 1,
// DIGIT bits per clock, least significant digit first. It also reports the
// unsigned borrow and the two's-complement overflow of the subtraction.
//
// Handshake: an operand pair is accepted in IDLE (in_valid & in_ready). The
// result is presented in DONE (out_valid) and held until out_ready.
// out_valid rises WIDTH/DIGIT clock edges after the accept edge.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b are valid
//   in_ready   block can accept operands (IDLE only)
//   a          minuend, WIDTH bits
//   b          subtrahend, WIDTH bits
//   out_valid  D/borrow/overflow are valid (DONE only)
//   out_ready  consumer takes the result
//   D          difference a - b modulo 2^WIDTH
//   borrow     1 iff a < b (unsigned)
//   overflow   two's-complement overflow of a - b
// ----------------------------------------------------------------------------
module seq_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             borrow,
    output logic             overflow
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             borrow_q;
    logic             ovf_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dig_sum;
    logic             last_dig;
    logic             accept;

    assign accept   = (state == IDLE) && in_valid;
    assign last_dig = (cnt_q == LAST_DIG);

    // Select the current digit of each captured operand. Constant-index
    // slices keep the mux free of variable part-select arithmetic.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_dig = a_q[i*DIGIT +: DIGIT];
                b_dig = b_q[i*DIGIT +: DIGIT];
            end
        end
    end

    // Subtraction digit: a + ~b + carry, carry seeded with 1 on accept.
    assign dig_sum = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT{1'b0}}, carry_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last_dig)  state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: operand capture, digit accumulation and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            carry_q <= 1'b1;
        end else if (state == RUN) begin
            for (int i = 0; i < NDIG; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    d_q[i*DIGIT +: DIGIT] <= dig_sum[DIGIT-1:0];
                end
            end
            carry_q <= dig_sum[DIGIT];
            cnt_q   <= cnt_q + 1'b1;
            if (last_dig) begin
                // The last digit's top bit is the result sign bit.
                borrow_q <= ~dig_sum[DIGIT];
                ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                            (dig_sum[DIGIT-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign D        = d_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

endmodule
